reg_wb_arbiter: RTL and testbench

Writeback arbiter and scoreboard for the 32x32 register file's single write port. Up to NUM_REQ writeback sources (ALU, load unit, multi-cycle unit) compete for the port through valid/ready handshakes. Grants are round-robin, and the winner's write is registered onto the register-file write controls. A per-register busy scoreboard tracks destinations that issue has reserved but that are not yet written back, for hazard detection.

---
 rtl/reg_wb_pkg.sv | 15 +
 rtl/reg_wb_arbiter_if.sv | 29 ++
 rtl/rr_arbiter.sv | 43 ++++
 rtl/reg_wb_arbiter.sv | 72 +++++++
 tb/tb_reg_wb_arbiter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/reg_wb_pkg.sv
// rtl/reg_wb_pkg.sv - shared register-file writeback constants and helpers
package reg_wb_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 1 << ADDR_W;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  // Index width for an n-way selector; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reg_wb_arbiter_if.sv
// rtl/reg_wb_arbiter_if.sv - writeback requester, issue-mark and register-file port bundle
interface reg_wb_arbiter_if #(
  parameter int NUM_REQ = 3
);
  import reg_wb_pkg::*;

  logic [NUM_REQ-1:0]        req_valid_i;
  logic [NUM_REQ*ADDR_W-1:0] req_addr_i;
  logic [NUM_REQ*DATA_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]        req_ready_o;
  logic                      wb_hold_i;
  logic                      mark_valid_i;
  logic [ADDR_W-1:0]         mark_addr_i;
  logic [NUM_REGS-1:0]       busy_o;
  logic                      RegWrite_o;
  logic [ADDR_W-1:0]         RDaddr_o;
  logic [DATA_W-1:0]         RDdata_o;

  modport master (
    output req_valid_i, req_addr_i, req_data_i, wb_hold_i, mark_valid_i, mark_addr_i,
    input  req_ready_o, busy_o, RegWrite_o, RDaddr_o, RDdata_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, req_data_i, wb_hold_i, mark_valid_i, mark_addr_i,
    output req_ready_o, busy_o, RegWrite_o, RDaddr_o, RDdata_o
  );

endinterface

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - generic N-way round-robin arbiter with hold
module rr_arbiter #(
  parameter int N     = 3,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N-1:0]     req_i,
  input  logic             hold_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W:0]   cand;
  logic             found;

  // Search upward from the pointer, wrapping at N; first valid requester wins.
  always_comb begin
    found = 1'b0;
    idx_o = '0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(N)) cand = cand - (IDX_W+1)'(N);
      if (!found && req_i[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        idx_o = cand[IDX_W-1:0];
      end
    end
  end

  assign grant_o = (found && !hold_i) ? (N'(1) << idx_o) : '0;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q <= '0;
    end else if (|grant_o) begin
      ptr_q <= (idx_o == IDX_W'(N-1)) ? '0 : idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - register-file write-port arbiter with busy scoreboard
module reg_wb_arbiter
  import reg_wb_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input logic           clk_i,
  input logic           rst_i,
  reg_wb_arbiter_if.slave bus
);

  localparam int IDX_W = idx_w(NUM_REQ);

  logic [NUM_REQ-1:0]  grant;
  logic [IDX_W-1:0]    win_idx;
  logic                xfer;
  logic [ADDR_W-1:0]   win_addr;
  logic [DATA_W-1:0]   win_data;
  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_nxt;
  logic                reg_write_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [DATA_W-1:0]   rd_data_q;

  // Reset is folded into hold so nothing handshakes while rst_i is high.
  rr_arbiter #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req_i   (bus.req_valid_i),
    .hold_i  (bus.wb_hold_i | rst_i),
    .grant_o (grant),
    .idx_o   (win_idx)
  );

  assign xfer     = |grant;
  assign win_addr = bus.req_addr_i[int'(win_idx)*ADDR_W +: ADDR_W];
  assign win_data = bus.req_data_i[int'(win_idx)*DATA_W +: DATA_W];

  // Clear before set so a same-cycle re-mark keeps the new producer outstanding.
  always_comb begin
    busy_nxt = busy_q;
    if (xfer) busy_nxt[win_addr] = 1'b0;
    if (bus.mark_valid_i && bus.mark_addr_i != REG_ZERO) busy_nxt[bus.mark_addr_i] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q      <= '0;
      reg_write_q <= 1'b0;
      rd_addr_q   <= '0;
      rd_data_q   <= '0;
    end else begin
      busy_q      <= busy_nxt;
      reg_write_q <= xfer && (win_addr != REG_ZERO);
      if (xfer) begin
        rd_addr_q <= win_addr;
        rd_data_q <= win_data;
      end
    end
  end

  assign bus.req_ready_o = grant;
  assign bus.busy_o      = busy_q;
  assign bus.RegWrite_o  = reg_write_q;
  assign bus.RDaddr_o    = rd_addr_q;
  assign bus.RDdata_o    = rd_data_q;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb/tb_reg_wb_arbiter.sv - directed self-checking bench for reg_wb_arbiter
module tb_reg_wb_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  reg_wb_arbiter_if #(.NUM_REQ(3)) bus ();

  reg_wb_arbiter #(.NUM_REQ(3)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid_i  = '0;
    bus.req_addr_i   = '0;
    bus.req_data_i   = '0;
    bus.wb_hold_i    = 1'b0;
    bus.mark_valid_i = 1'b0;
    bus.mark_addr_i  = '0;
  endtask

  task automatic set_req(input int k, input logic [4:0] a, input logic [31:0] d);
    bus.req_addr_i[k*5 +: 5]   = a;
    bus.req_data_i[k*32 +: 32] = d;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    bus.req_valid_i = 3'b111;
    for (int c = 0; c < 2; c++) begin
      #1;
      vectors++;
      if (bus.req_ready_o !== 3'b000) begin
        miscompares++;
        $display("FAIL reset_ready cyc%0d got %b exp 000", c, bus.req_ready_o);
      end
      tick();
      vectors++;
      if (bus.RegWrite_o !== 1'b0 || bus.busy_o !== 32'h0) begin
        miscompares++;
        $display("FAIL reset_state cyc%0d got we=%b busy=%h exp 0/0", c, bus.RegWrite_o, bus.busy_o);
      end
    end
    rst = 1'b0;
    bus.req_valid_i = '0;
    #1;
    vectors++;
    if (bus.RegWrite_o !== 1'b0 || bus.busy_o !== 32'h0 || bus.RDaddr_o !== 5'd0 || bus.RDdata_o !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_release got we=%b busy=%h a=%0d d=%h exp all 0",
               bus.RegWrite_o, bus.busy_o, bus.RDaddr_o, bus.RDdata_o);
    end
  endtask

  task automatic test_single_write();
    do_reset();
    bus.req_valid_i = 3'b010;
    set_req(1, 5'd5, 32'hDEADBEEF);
    #1;
    vectors++;
    if (bus.req_ready_o !== 3'b010) begin
      miscompares++;
      $display("FAIL single_ready got %b exp 010", bus.req_ready_o);
    end
    tick();
    bus.req_valid_i = '0;
    vectors++;
    if (bus.RegWrite_o !== 1'b1 || bus.RDaddr_o !== 5'd5 || bus.RDdata_o !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL single_write got we=%b a=%0d d=%h exp 1/5/deadbeef",
               bus.RegWrite_o, bus.RDaddr_o, bus.RDdata_o);
    end
    tick();
    vectors++;
    if (bus.RegWrite_o !== 1'b0 || bus.RDaddr_o !== 5'd5) begin
      miscompares++;
      $display("FAIL single_idle got we=%b a=%0d exp 0/5", bus.RegWrite_o, bus.RDaddr_o);
    end
  endtask

  // exp_g < 0 marks a held cycle with no grant expected.
  task automatic run_rr(input string name, input int exp_g[5], input logic hold_mask[5]);
    do_reset();
    for (int k = 0; k < 3; k++) set_req(k, 5'(10 + k), 32'hA000_0000 + k);
    bus.req_valid_i = 3'b111;
    for (int c = 0; c < 5; c++) begin
      bus.wb_hold_i = hold_mask[c];
      #1;
      vectors++;
      if (exp_g[c] < 0) begin
        if (bus.req_ready_o !== 3'b000) begin
          miscompares++;
          $display("FAIL %s_ready cyc%0d got %b exp 000", name, c, bus.req_ready_o);
        end
      end else if (bus.req_ready_o !== 3'(1 << exp_g[c])) begin
        miscompares++;
        $display("FAIL %s_ready cyc%0d got %b exp grant %0d", name, c, bus.req_ready_o, exp_g[c]);
      end
      tick();
      vectors++;
      if (exp_g[c] < 0) begin
        if (bus.RegWrite_o !== 1'b0) begin
          miscompares++;
          $display("FAIL %s_wp cyc%0d got we=%b exp 0", name, c, bus.RegWrite_o);
        end
      end else if (bus.RegWrite_o !== 1'b1 || bus.RDaddr_o !== 5'(10 + exp_g[c]) ||
                   bus.RDdata_o !== 32'hA000_0000 + exp_g[c]) begin
        miscompares++;
        $display("FAIL %s_wp cyc%0d got we=%b a=%0d d=%h exp req %0d",
                 name, c, bus.RegWrite_o, bus.RDaddr_o, bus.RDdata_o, exp_g[c]);
      end
    end
    idle_inputs();
  endtask

  task automatic test_fairness();
    int   g[5] = '{0, 1, 2, 0, 1};
    logic h[5] = '{0, 0, 0, 0, 0};
    run_rr("fair", g, h);
  endtask

  task automatic test_hold();
    int   g[5] = '{0, 1, -1, 2, 0};
    logic h[5] = '{0, 0, 1, 0, 0};
    run_rr("hold", g, h);
  endtask

  task automatic test_scoreboard();
    do_reset();
    bus.mark_valid_i = 1'b1;
    bus.mark_addr_i  = 5'd7;
    tick();
    bus.mark_valid_i = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      vectors++;
      if (bus.busy_o[7] !== 1'b1) begin
        miscompares++;
        $display("FAIL sb_busy7 cyc%0d got %b exp 1", c, bus.busy_o[7]);
      end
      if (c == 3) begin
        bus.req_valid_i = 3'b001;
        set_req(0, 5'd7, 32'h0000_0777);
      end
      tick();
    end
    bus.req_valid_i = '0;
    vectors++;
    if (bus.busy_o !== 32'h0 || bus.RegWrite_o !== 1'b1 || bus.RDaddr_o !== 5'd7) begin
      miscompares++;
      $display("FAIL sb_clear7 got busy=%h we=%b a=%0d exp 0/1/7", bus.busy_o, bus.RegWrite_o, bus.RDaddr_o);
    end
    bus.mark_valid_i = 1'b1;
    bus.mark_addr_i  = 5'd9;
    tick();
    bus.req_valid_i = 3'b001;
    set_req(0, 5'd9, 32'h0000_0999);
    tick();
    idle_inputs();
    vectors++;
    if (bus.busy_o !== (32'h1 << 9) || bus.RegWrite_o !== 1'b1 || bus.RDaddr_o !== 5'd9) begin
      miscompares++;
      $display("FAIL sb_setwins9 got busy=%h we=%b a=%0d exp 00000200/1/9",
               bus.busy_o, bus.RegWrite_o, bus.RDaddr_o);
    end
  endtask

  task automatic test_reg_zero();
    do_reset();
    bus.mark_valid_i = 1'b1;
    bus.mark_addr_i  = 5'd0;
    tick();
    bus.mark_valid_i = 1'b0;
    vectors++;
    if (bus.busy_o !== 32'h0) begin
      miscompares++;
      $display("FAIL r0_mark got busy=%h exp 0", bus.busy_o);
    end
    bus.req_valid_i = 3'b100;
    set_req(2, 5'd0, 32'h0000_1234);
    #1;
    vectors++;
    if (bus.req_ready_o !== 3'b100) begin
      miscompares++;
      $display("FAIL r0_ready got %b exp 100", bus.req_ready_o);
    end
    tick();
    bus.req_valid_i = '0;
    vectors++;
    if (bus.RegWrite_o !== 1'b0 || bus.busy_o !== 32'h0 || bus.RDdata_o !== 32'h0000_1234) begin
      miscompares++;
      $display("FAIL r0_write got we=%b busy=%h d=%h exp 0/0/00001234",
               bus.RegWrite_o, bus.busy_o, bus.RDdata_o);
    end
  endtask

  initial begin
    idle_inputs();
    #1;
    test_reset();
    test_single_write();
    test_fairness();
    test_hold();
    test_scoreboard();
    test_reg_zero();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
